event_debouncer: RTL

EVENT_DEBOUNCER -- requirements
Module: event_debouncer

---
 rtl/event_debouncer.sv | 101 ++++++++++
 1 files changed

// File: rtl/event_debouncer.sv
// Pushbutton/event debouncer: 2-flop synchronizer feeding a four-state qualify FSM
// that emits one-cycle press/release pulses and counts rejected bounces.
module event_debouncer #(
    parameter int STABLE_CYCLES = 16'd50000,
    parameter int CNT_W         = 16
) (
    input  logic       CLK,
    input  logic       CLEAR,
    input  logic       BTN_IN,
    output logic       BTN_LEVEL,
    output logic       PRESS_PULSE,
    output logic       RELEASE_PULSE,
    output logic [1:0] STATE,
    output logic [7:0] GLITCH_CNT
);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_reg;
    logic             btn_s_reg;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;

    // BTN_IN is asynchronous; only btn_s_reg may be observed by the FSM.
    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            sync1_reg <= 1'b0;
            btn_s_reg <= 1'b0;
        end else begin
            sync1_reg <= BTN_IN;
            btn_s_reg <= sync1_reg;
        end
    end

    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            BTN_LEVEL     <= 1'b0;
            PRESS_PULSE   <= 1'b0;
            RELEASE_PULSE <= 1'b0;
            GLITCH_CNT    <= 8'd0;
        end else begin
            PRESS_PULSE   <= 1'b0;
            RELEASE_PULSE <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (btn_s_reg) begin
                        state_reg <= PRESS_WAIT;
                        cnt_reg   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    // A bounce wins over acceptance even on the terminal count.
                    if (!btn_s_reg) begin
                        state_reg <= IDLE;
                        if (GLITCH_CNT != 8'hFF)
                            GLITCH_CNT <= GLITCH_CNT + 8'd1;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= PRESSED;
                        BTN_LEVEL   <= 1'b1;
                        PRESS_PULSE <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!btn_s_reg) begin
                        state_reg <= RELEASE_WAIT;
                        cnt_reg   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s_reg) begin
                        state_reg <= PRESSED;
                        if (GLITCH_CNT != 8'hFF)
                            GLITCH_CNT <= GLITCH_CNT + 8'd1;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg     <= IDLE;
                        BTN_LEVEL     <= 1'b0;
                        RELEASE_PULSE <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign STATE = state_reg;

endmodule
